// File: rtl/in_port_capture.sv
// Input port: synchronizes and debounces 8 switches plus a load button, then captures the byte.
// Optional sticky overrun flag is built only when IN_PORT_OVERRUN_EN is defined.
module in_port_capture #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  switches,
  input  logic        strobe,
  input  logic        InPortRead,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        overrun
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [7:0]      sw_meta_q, sw_s_q;
  logic            stb_meta_q, stb_s_q;
  logic            deb_level_q, deb_level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            ready_q, ready_d;
  logic            cap;

  always_ff @(posedge clk) begin
    if (clr) begin
      sw_meta_q   <= '0;
      sw_s_q      <= '0;
      stb_meta_q  <= 1'b0;
      stb_s_q     <= 1'b0;
      deb_level_q <= 1'b0;
      cnt_q       <= '0;
      data_q      <= '0;
      ready_q     <= 1'b0;
    end else begin
      sw_meta_q   <= switches;
      sw_s_q      <= sw_meta_q;
      stb_meta_q  <= strobe;
      stb_s_q     <= stb_meta_q;
      deb_level_q <= deb_level_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
    end
  end

  // Level flips only after DEBOUNCE_CYCLES consecutive mismatching samples; a rising flip is a capture.
  always_comb begin
    deb_level_d = deb_level_q;
    cnt_d       = cnt_q;
    cap         = 1'b0;
    if (stb_s_q == deb_level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      deb_level_d = stb_s_q;
      cnt_d       = '0;
      cap         = stb_s_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    data_d  = data_q;
    ready_d = ready_q;
    if (cap) begin
      data_d  = sw_s_q;
      ready_d = 1'b1;
    end else if (InPortRead) begin
      ready_d = 1'b0;
    end
  end

`ifdef IN_PORT_OVERRUN_EN
  logic ovr_q, ovr_d;

  // A read coinciding with a capture consumed the old value, so no overrun.
  always_comb begin
    ovr_d = ovr_q;
    if (cap) begin
      if (InPortRead) begin
        ovr_d = 1'b0;
      end else if (ready_q) begin
        ovr_d = 1'b1;
      end
    end else if (InPortRead) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ovr_q <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun = ovr_q;
`else
  assign overrun = 1'b0;
`endif

  assign data_out   = {24'h0, data_q};
  assign data_ready = ready_q;

endmodule

// File: tb/tb_in_port_capture.sv
// Self-checking bench for in_port_capture: directed test-plan scenarios plus randomized stimulus
// compared every cycle against a sample-window reference model.
module tb_in_port_capture;

  localparam int unsigned Deb = 16;
`ifdef IN_PORT_OVERRUN_EN
  localparam bit OvrEn = 1'b1;
`else
  localparam bit OvrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr;
  logic [7:0]  switches;
  logic        strobe;
  logic        InPortRead;
  logic [31:0] data_out;
  logic        data_ready;
  logic        overrun;

  in_port_capture #(.DEBOUNCE_CYCLES(Deb)) dut (
    .clk        (clk),
    .clr        (clr),
    .switches   (switches),
    .strobe     (strobe),
    .InPortRead (InPortRead),
    .data_out   (data_out),
    .data_ready (data_ready),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: raw inputs reach the logic two edges late; the debounced level flips once
  // the most recent Deb synchronized samples since the last flip all disagree with it.
  logic [8:0] m_meta, m_s;
  bit         m_level, m_cap, m_all;
  bit         stb_win[$];
  logic [7:0] m_data;
  bit         m_ready, m_ovr;

  always @(posedge clk) begin
    if (clr) begin
      m_meta = '0; m_s = '0; m_level = 0; stb_win.delete();
      m_data = '0; m_ready = 0; m_ovr = 0;
    end else begin
      stb_win.push_back(m_s[8]);
      if (stb_win.size() > Deb) void'(stb_win.pop_front());
      m_all = (stb_win.size() == Deb);
      foreach (stb_win[i]) if (stb_win[i] == m_level) m_all = 0;
      m_cap = 0;
      if (m_all) begin
        m_level = !m_level;
        stb_win.delete();
        m_cap = m_level;
      end
      if (m_cap) begin
        if (InPortRead) m_ovr = 0;
        else if (m_ready) m_ovr = OvrEn;
        m_ready = 1;
        m_data  = m_s[7:0];
      end else if (InPortRead) begin
        m_ready = 0;
        m_ovr   = 0;
      end
      m_s    = m_meta;
      m_meta = {strobe, switches};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check_val("model_data", data_out, {24'h0, m_data});
      check_val("model_ready", {31'h0, data_ready}, {31'h0, m_ready});
      check_val("model_ovr", {31'h0, overrun}, {31'h0, m_ovr});
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic capture(input logic [7:0] v);
    switches = v;
    strobe   = 1'b1;
    run(Deb + 2);
    strobe = 1'b0;
    run(Deb + 4);
  endtask

  task automatic read_pulse();
    InPortRead = 1'b1;
    run(1);
    InPortRead = 1'b0;
  endtask

  int hold;

  initial begin
    clr = 1'b1; switches = '0; strobe = 1'b0; InPortRead = 1'b0;
    run(2);
    chk_en = 1'b1;
    check_val("rst_data", data_out, 32'h0);
    check_val("rst_ready", {31'h0, data_ready}, 32'h0);
    check_val("rst_ovr", {31'h0, overrun}, 32'h0);
    clr = 1'b0;

    // Short press is rejected
    switches = 8'h5A; strobe = 1'b1;
    run(10);
    strobe = 1'b0;
    run(30);
    check_val("glitch_ready", {31'h0, data_ready}, 32'h0);
    check_val("glitch_data", data_out, 32'h0);

    // Capture latency: visible exactly 18 edges after the strobe change
    switches = 8'hA5; strobe = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      run(1);
      if (i < 18) begin
        check_val("lat_ready_lo", {31'h0, data_ready}, 32'h0);
        check_val("lat_data_lo", data_out, 32'h0);
      end else begin
        check_val("lat_ready_hi", {31'h0, data_ready}, 32'h1);
        check_val("lat_data_hi", data_out, 32'h000000A5);
      end
    end
    strobe = 1'b0;
    run(Deb + 4);
    read_pulse();

    capture(8'h3C);
    check_val("cap3c_ready", {31'h0, data_ready}, 32'h1);
    read_pulse();
    check_val("read_ready", {31'h0, data_ready}, 32'h0);
    check_val("read_data", data_out, 32'h0000003C);

    capture(8'h11);
    capture(8'h22);
    check_val("ovr_data", data_out, 32'h00000022);
    check_val("ovr_ready", {31'h0, data_ready}, 32'h1);
    check_val("ovr_flag", {31'h0, overrun}, {31'h0, OvrEn});
    read_pulse();
    check_val("ovr_clr_ready", {31'h0, data_ready}, 32'h0);
    check_val("ovr_clr_flag", {31'h0, overrun}, 32'h0);

    // Read on the exact capture edge
    capture(8'h55);
    switches = 8'h77; strobe = 1'b1;
    run(Deb + 1);
    read_pulse();
    check_val("rdcap_data", data_out, 32'h00000077);
    check_val("rdcap_ready", {31'h0, data_ready}, 32'h1);
    check_val("rdcap_ovr", {31'h0, overrun}, 32'h0);
    strobe = 1'b0;
    run(Deb + 4);
    read_pulse();

    // Reset while the counter sits at 8 with the button held
    switches = 8'h99; strobe = 1'b1;
    run(10);
    clr = 1'b1;
    run(1);
    clr = 1'b0;
    check_val("midclr_data", data_out, 32'h0);
    check_val("midclr_ready", {31'h0, data_ready}, 32'h0);
    for (int i = 1; i <= 18; i++) begin
      run(1);
      if (i < 18) check_val("midclr_wait", {31'h0, data_ready}, 32'h0);
      else begin
        check_val("midclr_ready_hi", {31'h0, data_ready}, 32'h1);
        check_val("midclr_data_hi", data_out, 32'h00000099);
      end
    end
    strobe = 1'b0;
    run(Deb + 4);

    // Randomized phase, checked by the model every cycle
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        strobe = ~strobe;
        hold = $urandom_range(1, 40);
      end
      hold--;
      switches   = 8'($urandom);
      InPortRead = ($urandom_range(0, 7) == 0);
      clr        = ($urandom_range(0, 299) == 0);
      run(1);
    end
    clr = 1'b0; InPortRead = 1'b0;
    run(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
